// File: rtl/tdt_dm_cdc_pkg.sv
// Shared definitions for the debug-module toggle-handshake CDC:
// FSM encoding and default data/counter widths.
package tdt_dm_cdc_pkg;

    localparam int TDT_DM_CDC_DATA_W = 32;
    localparam int TDT_DM_CDC_CNT_W  = 8;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_VALID = 1'b1
    } rcv_state_e;

endpackage

// File: rtl/tdt_dm_tgl_det.sv
// Toggle detector: remembers the previous level of a synchronized toggle and
// flags any change. Shared by the request receiver and the ack receiver.
module tdt_dm_tgl_det (
    input  logic clk_i,
    input  logic rst_i,
    input  logic tgl_i,
    output logic edge_o
);

    logic tgl_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            tgl_q <= 1'b0;
        end else begin
            tgl_q <= tgl_i;
        end
    end

    assign edge_o = tgl_i ^ tgl_q;

endmodule

// File: rtl/tdt_dm_cdc_req_rcv.sv
// Destination side of the toggle-handshake CDC: captures the quasi-static
// source word on each request toggle and hands it out over valid/ready.
module tdt_dm_cdc_req_rcv
    import tdt_dm_cdc_pkg::*;
#(
    parameter int DATA_WIDTH = TDT_DM_CDC_DATA_W,
    parameter int CNT_WIDTH  = TDT_DM_CDC_CNT_W
) (
    input  logic                  dst_clk,
    input  logic                  dst_rst,
    input  logic                  req_tgl_sync,
    input  logic [DATA_WIDTH-1:0] src_data,
    output logic                  dout_vld,
    output logic [DATA_WIDTH-1:0] dout_data,
    input  logic                  dout_rdy,
    output logic                  ack_tgl,
    output logic                  busy,
    output logic [CNT_WIDTH-1:0]  xfer_cnt,
    output logic                  err_ovf,
    input  logic                  err_clr
);

    rcv_state_e            state_q;
    logic [DATA_WIDTH-1:0] data_q;
    logic                  ack_q;
    logic [CNT_WIDTH-1:0]  cnt_q;
    logic [CNT_WIDTH-1:0]  cnt_d;
    logic                  err_q;
    logic                  req_edge;

    tdt_dm_tgl_det u_req_det (
        .clk_i  (dst_clk),
        .rst_i  (dst_rst),
        .tgl_i  (req_tgl_sync),
        .edge_o (req_edge)
    );

    assign cnt_d = cnt_q + CNT_WIDTH'(1);

    always_ff @(posedge dst_clk or posedge dst_rst) begin
        if (dst_rst) begin
            state_q <= ST_IDLE;
            data_q  <= '0;
            ack_q   <= 1'b0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            // A toggle arriving while a word is still held is dropped; set beats clear.
            if (req_edge && (state_q == ST_VALID)) begin
                err_q <= 1'b1;
            end else if (err_clr) begin
                err_q <= 1'b0;
            end

            case (state_q)
                ST_IDLE: begin
                    if (req_edge) begin
                        state_q <= ST_VALID;
                        data_q  <= src_data;
                    end
                end
                ST_VALID: begin
                    if (dout_rdy) begin
                        state_q <= ST_IDLE;
                        ack_q   <= ~ack_q;
                        cnt_q   <= cnt_d;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign dout_vld  = (state_q == ST_VALID);
    assign busy      = (state_q != ST_IDLE);
    assign dout_data = data_q;
    assign ack_tgl   = ack_q;
    assign xfer_cnt  = cnt_q;
    assign err_ovf   = err_q;

endmodule

// File: doc/tdt_dm_cdc_req_rcv.md
# tdt_dm_cdc_req_rcv

Destination-side receiver of the debug module's toggle-handshake clock-domain crossing. It sits directly downstream of the request-toggle flop-chain synchronizer. It detects each toggle of the synchronized request and captures the quasi-static source data bus. It then presents the data on a valid/ready interface to local debug logic and returns an acknowledge toggle, which the source domain re-synchronizes.

## Interface
- `DATA_WIDTH`, 32, width of the crossed data word
- `CNT_WIDTH`, 8, width of the completed-transfer counter
- `dst_clk` in 1: destination clock; all logic is on its rising edge
- `dst_rst` in 1: asynchronous, active-high reset
- `req_tgl_sync` in 1: request toggle, already synchronized to `dst_clk`; its synchronizer resets to 0
- `src_data` in DATA_WIDTH: source data; held stable by the source from its request toggle until it observes `ack_tgl`
- `dout_vld` out 1: captured word valid
- `dout_data` out DATA_WIDTH: captured word
- `dout_rdy` in 1: local consumer ready
- `ack_tgl` out 1: flips once per completed transfer; goes to the source-domain synchronizer
- `busy` out 1: high when not IDLE
- `xfer_cnt` out CNT_WIDTH: completed transfers, wraps modulo 2^CNT_WIDTH
- `err_ovf` out 1: sticky protocol-violation flag
- `err_clr` in 1: clears `err_ovf`

## Operation
- `req_tgl_q` is a register holding the previous `req_tgl_sync` and resets to 0.
- `req_edge` = `req_tgl_sync` XOR `req_tgl_q`. It is combinational and sampled at each clock edge.
- FSM states are IDLE and VALID.
  - IDLE to VALID on `req_edge`. On that edge `dout_data` <= `src_data`. Sampling is safe because the data settled at least SYNC stages before the toggle arrived.
  - VALID to IDLE when `dout_vld && dout_rdy`. On that edge `ack_tgl` flips and `xfer_cnt` increments.
- `dout_vld` = (state == VALID). `busy` = (state != IDLE).
- `dout_data` changes only on an IDLE capture. It holds its value in VALID and after the handshake.
- Overflow: a `req_edge` while in VALID, including the handshake cycle, sets `err_ovf`. That request is dropped: no capture, no ack. `req_tgl_q` still tracks the input, so the dropped toggle is not re-detected.
- `err_clr` and a new overflow in the same cycle: set wins.
- `dout_rdy` while IDLE is ignored.

## Timing
- Reset values:
  - state IDLE, `dout_vld`=0, `dout_data`=0, `ack_tgl`=0, `busy`=0, `xfer_cnt`=0, `err_ovf`=0, `req_tgl_q`=0.
- Capture latency: `req_edge` true at edge n gives `dout_vld`=1 and the new `dout_data` after edge n.
- Handshake sampled at edge m gives, after edge m, `dout_vld`=0, `ack_tgl` flipped and `xfer_cnt`+1.
- Back-to-back: the earliest new capture is at edge m+1, giving `dout_vld` after m+1. There is a single-cycle minimum gap with `dout_vld` low.
- `xfer_cnt` wraps from 2^CNT_WIDTH-1 to 0 with no flag.
- Reset mid-transfer: all state returns to reset values immediately (async) and the pending word is lost. The source side must be reset together so toggle parity matches (both 0).
- All outputs are registered; there is no combinational path from inputs to outputs.

## Structure
- Shared package `tdt_dm_cdc_pkg`:
  - FSM state encoding (IDLE=1'b0, VALID=1'b1).
  - Default widths `TDT_DM_CDC_DATA_W`=32 and `TDT_DM_CDC_CNT_W`=8.
- Natural sub-module: `tdt_dm_tgl_det`, holding the `req_tgl_q` register and the `req_edge` XOR, with async active-high reset. It is reused by the source-side ack receiver.
- The synchronizer itself stays outside this block.

## Test plan
- Single transfer: `src_data`=0xDEADBEEF, toggle `req_tgl_sync` 0 to 1, hold `dout_rdy`=1. Expect `dout_vld` for exactly 1 cycle with 0xDEADBEEF, `ack_tgl`=1, `xfer_cnt`=1.
- Backpressure: toggle the request with `dout_rdy`=0 for 10 cycles. Expect `dout_vld` held and `dout_data` stable, `ack_tgl` unchanged. On `dout_rdy`=1, expect `ack_tgl` to flip the next cycle.
- Overflow: while VALID, toggle the request again. Expect `err_ovf`=1 and `dout_data` unchanged. After the handshake only one ack flip, and `xfer_cnt` advances by 1. Pulse `err_clr` and expect `err_ovf`=0. Assert `err_clr` in the same cycle as a new overflow and expect `err_ovf`=1.
- Counter wrap: CNT_WIDTH=8, 256 transfers with alternating data 0x0/0xFFFFFFFF. Expect `xfer_cnt`=0, `ack_tgl`=0, all data correct.
- Reset mid-operation: assert `dst_rst` while VALID with 0x12345678 captured. Expect all outputs at reset values asynchronously. After release with `req_tgl_sync`=0, no spurious `dout_vld`.
